// File: rtl/seq_frame_tx.sv
// seq_frame_tx: serial frame transmitter for the single-wire 1011-sync link.
// Latency: first frame bit (sync '1') appears on sout the cycle after the accept edge.
// Backpressure: start is only taken while ready=1; requests while busy are dropped.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-low reset
//   start  - frame request, accepted when ready=1
//   data   - payload word, sampled on the accept edge only
//   sout   - serial line, idles at 0
//   ready  - idle and able to accept start
//   busy   - frame or gap in progress (always ~ready)
//   done   - one-cycle pulse in the first cycle after the last frame bit
module seq_frame_tx #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1,
  parameter int GAP_BITS  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              sout,
  output logic              ready,
  output logic              busy,
  output logic              done
);

  // The one counter is reused by SYNC, DATA and GAP; it must hold the
  // largest per-state index (count-1) without wrapping.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  localparam int CNT_MAX = max3(4, DATA_W, GAP_BITS);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    DATA = 3'd2,
    PAR  = 3'd3,
    GAP  = 3'd4
  } state_t;

  // state names the bit currently on sout; cnt is its index within that state.
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic              par;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
      par   <= 1'b0;
      sout  <= 1'b0;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sout <= 1'b0;
          if (start) begin
            state <= SYNC;
            cnt   <= '0;
            shreg <= data;
            par   <= ^data;
            sout  <= 1'b1;          // sync bit 0
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end

        SYNC: begin
          if (cnt == CNT_W'(3)) begin
            state <= DATA;
            cnt   <= '0;
            sout  <= shreg[DATA_W-1];
            shreg <= shreg << 1;
          end else begin
            cnt  <= cnt + CNT_W'(1);
            // Remaining sync bits after the leading 1 are 0,1,1: the next
            // bit is 0 only when leaving sync bit 0.
            sout <= (cnt != CNT_W'(0));
          end
        end

        DATA: begin
          if (cnt == CNT_W'(DATA_W - 1)) begin
            cnt <= '0;
            if (PARITY_EN != 0) begin
              state <= PAR;
              sout  <= par;
            end else begin
              sout <= 1'b0;
              done <= 1'b1;
              if (GAP_BITS > 0) begin
                state <= GAP;
              end else begin
                state <= IDLE;
                ready <= 1'b1;
                busy  <= 1'b0;
              end
            end
          end else begin
            cnt   <= cnt + CNT_W'(1);
            sout  <= shreg[DATA_W-1];
            shreg <= shreg << 1;
          end
        end

        PAR: begin
          cnt  <= '0;
          sout <= 1'b0;
          done <= 1'b1;
          if (GAP_BITS > 0) begin
            state <= GAP;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end

        GAP: begin
          sout <= 1'b0;
          if (cnt == CNT_W'(GAP_BITS - 1)) begin
            state <= IDLE;
            cnt   <= '0;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          sout  <= 1'b0;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// tb_seq_frame_tx: directed bench for seq_frame_tx (default build plus a
// PARITY_EN=0 build sharing clock and reset).
// Ports: none (top-level bench).
module tb_seq_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start_np;
  logic [7:0] data, data_np;
  logic       sout, ready, busy, done;
  logic       sout_np, ready_np, busy_np, done_np;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_q[$];
  logic [3:0] lb = '0;   // loopback window: last sout values seen at rising edges

  always #5 clk = ~clk;

  seq_frame_tx #(.DATA_W(8), .PARITY_EN(1), .GAP_BITS(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .data(data),
    .sout(sout), .ready(ready), .busy(busy), .done(done)
  );

  seq_frame_tx #(.DATA_W(8), .PARITY_EN(0), .GAP_BITS(2)) u_dut_np (
    .clk(clk), .rst(rst), .start(start_np), .data(data_np),
    .sout(sout_np), .ready(ready_np), .busy(busy_np), .done(done_np)
  );

  // Cycle stamp of every accept edge of the main instance, plus the loopback window.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    lb  <= {lb[2:0], sout};
    if (rst === 1'b1 && start === 1'b1 && ready === 1'b1) acc_q.push_back(cyc);
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at the falling edge just after the accept edge. Checks the 13
  // frame bits, the done cycle, both gap cycles and the return of ready.
  task automatic frame_check(input logic [7:0] d, input bit inject, input string tag,
                             output logic [12:0] got);
    logic [12:0] exp;
    exp = {4'b1011, d, ^d};
    got = '0;
    for (int k = 0; k < 13; k++) begin
      got[12-k] = sout;
      chk($sformatf("%s_bit%0d", tag, k), {29'd0, sout, busy, done}, {29'd0, exp[12-k], 2'b10});
      if (k == 3) chk({tag, "_sync_det"}, {28'd0, lb[2:0], sout}, 32'hB);
      if (inject && k == 5) begin
        start = 1'b1;
        data  = 8'hFF;
      end
      if (inject && k == 6) start = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_done"},  {28'd0, sout, ready, busy, done}, 32'b0011);
    @(negedge clk);
    chk({tag, "_gap1"},  {28'd0, sout, ready, busy, done}, 32'b0010);
    @(negedge clk);
    chk({tag, "_ready"}, {28'd0, sout, ready, busy, done}, 32'b0100);
  endtask

  initial begin
    logic [12:0] got;
    logic [11:0] exp12;
    int n0;

    // Reset held with start high: must stay idle.
    rst = 1'b0; start = 1'b1; data = 8'hFF; start_np = 1'b0; data_np = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset_idle%0d", i), {28'd0, sout, ready, busy, done}, 32'b0100);
    end
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {28'd0, sout, ready, busy, done}, 32'b0100);
    chk("no_accept_in_reset", acc_q.size(), 0);

    // Single frame A5: 1011 10100101 parity 0.
    data = 8'hA5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    frame_check(8'hA5, 1'b0, "a5", got);
    chk("a5_vector", {19'd0, got}, {19'd0, 13'b1011101001010});

    // Parity of 07 is 1.
    data = 8'h07; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    frame_check(8'h07, 1'b0, "p07", got);
    chk("p07_parity_bit", {31'd0, got[0]}, 32'd1);

    // Parity disabled: 12 bits, done right after the last payload bit.
    exp12 = 12'b1011_0000_0111;
    data_np = 8'h07; start_np = 1'b1;
    @(negedge clk);
    start_np = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("np_bit%0d", k), {29'd0, sout_np, busy_np, done_np}, {29'd0, exp12[11-k], 2'b10});
      @(negedge clk);
    end
    chk("np_done",  {28'd0, sout_np, ready_np, busy_np, done_np}, 32'b0011);
    @(negedge clk);
    chk("np_gap1",  {28'd0, sout_np, ready_np, busy_np, done_np}, 32'b0010);
    @(negedge clk);
    chk("np_ready", {28'd0, sout_np, ready_np, busy_np, done_np}, 32'b0100);

    // start + data=FF pulsed at frame bit 5 is ignored.
    data = 8'h5A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n0 = acc_q.size();
    frame_check(8'h5A, 1'b1, "busy_ign", got);
    @(negedge clk);
    chk("busy_ign_still_idle", {28'd0, sout, ready, busy, done}, 32'b0100);
    chk("busy_ign_no_accept", acc_q.size() - n0, 0);

    // Back-to-back with start held high.
    n0 = acc_q.size();
    data = 8'h3C; start = 1'b1;
    @(negedge clk);
    data = 8'hC3;
    frame_check(8'h3C, 1'b0, "b2b_1", got);
    @(negedge clk);
    frame_check(8'hC3, 1'b0, "b2b_2", got);
    start = 1'b0;
    chk("b2b_accepts", acc_q.size() - n0, 2);
    if (acc_q.size() >= n0 + 2) chk("b2b_spacing", acc_q[n0+1] - acc_q[n0], 16);

    // Reset asserted at frame bit 7 aborts the frame.
    @(negedge clk);
    data = 8'h96; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 7; k++) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_idle", {28'd0, sout, ready, busy, done}, 32'b0100);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_release_idle", {28'd0, sout, ready, busy, done}, 32'b0100);
    data = 8'hE1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    frame_check(8'hE1, 1'b0, "after_rst", got);
    chk("after_rst_vector", {19'd0, got}, {19'd0, 13'b1011111000010});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
